// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern source: pixel packing, pattern codes,
// colour-bar palette and the counter-width helper.
package video_pkg;

  localparam int PIX_R_LSB = 16;
  localparam int PIX_B_LSB = 8;
  localparam int PIX_G_LSB = 0;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Bar palette in {R,B,G} packing, left to right across the line
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFF00FF;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h0000FF;
  localparam logic [23:0] BAR_MAGENTA = 24'hFFFF00;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h00FF00;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    logic [23:0] p;
    p = '0;
    p[PIX_R_LSB +: 8] = r;
    p[PIX_G_LSB +: 8] = g;
    p[PIX_B_LSB +: 8] = b;
    return p;
  endfunction

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  // Bits needed to count 0..value-1, never less than one
  function automatic int clogb2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational pixel generator: (x, y, frame count, pattern, colour) -> 24-bit pixel.
// The top feeds it the coordinates of the next pixel so the result can be registered directly.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080,
  parameter int CHECKER_LOG2 = 3
) (
  input  logic [clogb2(FRAME_WIDTH)-1:0]  x,
  input  logic [clogb2(FRAME_HEIGHT)-1:0] y,
  input  logic [7:0]                      frame_cnt,
  input  logic [1:0]                      pattern,
  input  logic [23:0]                     color,
  output logic [23:0]                     pixel
);

  localparam int XW = clogb2(FRAME_WIDTH);
  localparam logic [XW+2:0] W_DIV = (XW+3)'(FRAME_WIDTH);

  logic [2:0] bar_idx;
  logic       checker_odd;

  always_comb begin
    // x*8/W is always below 8, so the last bar absorbs any remainder
    bar_idx     = 3'({x, 3'b000} / W_DIV);
    checker_odd = 1'(x >> CHECKER_LOG2) ^ 1'(y >> CHECKER_LOG2);
    pixel       = color;
    case (pattern)
      PAT_SOLID: pixel = color;
      PAT_BARS:  pixel = bar_color(bar_idx);
      PAT_GRAD:  pixel = pack_rgb(8'(x), 8'(y), frame_cnt);
      PAT_CHECK: pixel = checker_odd ? ~color : color;
      default:   pixel = color;
    endcase
  end

endmodule

// File: rtl/video_frame_source.sv
// AXI4-Stream test-pattern frame source; first pixel one cycle after enable, one pixel per cycle.
// Outputs are registered and held while tready is low; enable only takes effect at frame boundaries.
module video_frame_source
  import video_pkg::*;
#(
  parameter int FRAME_WIDTH      = 1920,
  parameter int FRAME_HEIGHT     = 1080,
  parameter int FRAME_GAP_CYCLES = 16,
  parameter int CHECKER_LOG2     = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] fill_color,
  output logic [23:0] m_axis_video_tdata_out,
  output logic        m_axis_video_tvalid_out,
  input  logic        m_axis_video_tready_out,
  output logic        m_axis_video_tuser_out,
  output logic        m_axis_video_tlast_out,
  output logic        frame_done,
  output logic        busy
);

  localparam int XW = clogb2(FRAME_WIDTH);
  localparam int YW = clogb2(FRAME_HEIGHT);
  localparam int GW = clogb2(FRAME_GAP_CYCLES + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_HEIGHT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic [23:0] color_q, color_d;
  logic [23:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tuser_q, tuser_d;
  logic        tlast_q, tlast_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;

  logic          hs;
  logic          start;
  logic          load;
  logic [XW-1:0] gen_x;
  logic [YW-1:0] gen_y;
  logic [7:0]    gen_f;
  logic [1:0]    gen_pat;
  logic [23:0]   gen_color;
  logic [23:0]   gen_pix;

  assign hs = tvalid_q & m_axis_video_tready_out;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_cnt_d  = frame_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    pat_d        = pat_q;
    color_d      = color_q;
    tvalid_d     = tvalid_q;
    tuser_d      = tuser_q;
    tlast_d      = tlast_q;
    frame_done_d = 1'b0;
    start        = 1'b0;
    load         = 1'b0;
    gen_x        = x_q;
    gen_y        = y_q;
    gen_f        = frame_cnt_q;
    gen_pat      = pat_q;
    gen_color    = color_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) start = 1'b1;
      end
      ST_ACTIVE: begin
        if (hs) begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            x_d          = '0;
            y_d          = '0;
            tvalid_d     = 1'b0;
            tuser_d      = 1'b0;
            tlast_d      = 1'b0;
            if (FRAME_GAP_CYCLES > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end else if (enable) begin
              start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
            load    = 1'b1;
            gen_x   = x_d;
            gen_y   = y_d;
            tuser_d = 1'b0;
            tlast_d = (x_d == X_LAST);
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (enable) start = 1'b1;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start: latch config and present pixel (0,0) with the updated frame count
    if (start) begin
      state_d   = ST_ACTIVE;
      pat_d     = pattern_sel;
      color_d   = fill_color;
      x_d       = '0;
      y_d       = '0;
      tvalid_d  = 1'b1;
      tuser_d   = 1'b1;
      tlast_d   = 1'b0;
      load      = 1'b1;
      gen_x     = '0;
      gen_y     = '0;
      gen_f     = frame_cnt_d;
      gen_pat   = pattern_sel;
      gen_color = fill_color;
    end
  end

  assign tdata_d = load ? gen_pix : tdata_q;
  assign busy_d  = (state_d != ST_IDLE);

  video_pattern_gen #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .CHECKER_LOG2 (CHECKER_LOG2)
  ) u_pattern_gen (
    .x         (gen_x),
    .y         (gen_y),
    .frame_cnt (gen_f),
    .pattern   (gen_pat),
    .color     (gen_color),
    .pixel     (gen_pix)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      frame_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      pat_q        <= '0;
      color_q      <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_cnt_q  <= frame_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      pat_q        <= pat_d;
      color_q      <= color_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign m_axis_video_tdata_out  = tdata_q;
  assign m_axis_video_tvalid_out = tvalid_q;
  assign m_axis_video_tuser_out  = tuser_q;
  assign m_axis_video_tlast_out  = tlast_q;
  assign frame_done              = frame_done_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_video_frame_source.sv
// Scoreboard bench for video_frame_source on an 8x4 frame with a 2-cycle inter-frame gap.
module tb_video_frame_source;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int GAP = 2;
  localparam int CL  = 1;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] fill_color;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic        frame_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // {frame_end, tuser, tlast, tdata}
  logic [26:0] exp_q[$];
  logic [7:0]  f_model;
  int          pop_cnt;

  logic        fd_pend;
  logic        prev_stall;
  logic [25:0] prev_beat;
  logic        gap_on;
  int          gap_len;

  video_frame_source #(
    .FRAME_WIDTH      (W),
    .FRAME_HEIGHT     (H),
    .FRAME_GAP_CYCLES (GAP),
    .CHECKER_LOG2     (CL)
  ) dut (
    .aclk                    (aclk),
    .aresetn                 (aresetn),
    .enable                  (enable),
    .pattern_sel             (pattern_sel),
    .fill_color              (fill_color),
    .m_axis_video_tdata_out  (tdata),
    .m_axis_video_tvalid_out (tvalid),
    .m_axis_video_tready_out (tready),
    .m_axis_video_tuser_out  (tuser),
    .m_axis_video_tlast_out  (tlast),
    .frame_done              (frame_done),
    .busy                    (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pixel(input int x, input int y, input logic [7:0] f,
                                             input logic [1:0] sel, input logic [23:0] fill);
    logic [23:0] p;
    case (sel)
      2'd0: p = fill;
      2'd1: begin
        case ((x * 8) / W)
          0: p = 24'hFFFFFF;
          1: p = 24'hFF00FF;
          2: p = 24'h00FFFF;
          3: p = 24'h0000FF;
          4: p = 24'hFFFF00;
          5: p = 24'hFF0000;
          6: p = 24'h00FF00;
          default: p = 24'h000000;
        endcase
      end
      2'd2: p = {8'(x), f, 8'(y)};
      default: p = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? ~fill : fill;
    endcase
    return p;
  endfunction

  // Monitor: scoreboard pops on handshake, stall stability, frame_done and gap length
  always @(negedge aclk) begin
    logic [26:0] e;
    if (!aresetn) begin
      fd_pend    = 1'b0;
      prev_stall = 1'b0;
      gap_on     = 1'b0;
    end else begin
      check_val("frame_done", frame_done, fd_pend);
      fd_pend = 1'b0;
      if (prev_stall) begin
        check_val("stall_vld", tvalid, 1);
        check_val("stall_beat", {tuser, tlast, tdata}, prev_beat);
      end
      prev_stall = tvalid && !tready;
      prev_beat  = {tuser, tlast, tdata};
      if (gap_on) begin
        if (tvalid) begin
          check_val("gap_len", gap_len, GAP);
          gap_on = 1'b0;
        end else if (!busy) begin
          gap_on = 1'b0;
        end else begin
          gap_len++;
        end
      end
      if (frame_done && !tvalid) begin
        gap_on  = 1'b1;
        gap_len = 1;
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("tdata", tdata, e[23:0]);
          check_val("tlast", tlast, e[24]);
          check_val("tuser", tuser, e[25]);
          fd_pend = e[26];
          pop_cnt++;
        end
      end
    end
  end

  task automatic push_frames(input logic [1:0] sel, input logic [23:0] fill, input int nfr);
    for (int fr = 0; fr < nfr; fr++) begin
      for (int yy = 0; yy < H; yy++)
        for (int xx = 0; xx < W; xx++)
          exp_q.push_back({(xx == W-1 && yy == H-1), (xx == 0 && yy == 0), (xx == W-1),
                           exp_pixel(xx, yy, f_model, sel, fill)});
      f_model++;
    end
  endtask

  task automatic do_reset();
    aresetn     = 1'b0;
    enable      = 1'b0;
    tready      = 1'b1;
    pattern_sel = 2'd0;
    fill_color  = 24'h0;
    #1;
    check_val("rst_tvalid", tvalid, 0);
    check_val("rst_tuser", tuser, 0);
    check_val("rst_tlast", tlast, 0);
    check_val("rst_tdata", tdata, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_busy", busy, 0);
    exp_q.delete();
    f_model = 8'd0;
    pop_cnt = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // Stream nfr frames; enable drops once drop_at beats of the last frame are taken,
  // fill switches to fill2 after chg_at beats (must not affect a frame in flight).
  task automatic run(input logic [1:0] sel, input logic [23:0] fill, input int nfr,
                     input bit rnd, input int drop_at, input int chg_at, input logic [23:0] fill2);
    int  limit;
    bit  done;
    done    = 1'b0;
    pop_cnt = 0;
    limit   = (nfr - 1) * W * H + drop_at;
    push_frames(sel, fill, nfr);
    @(posedge aclk); #1;
    pattern_sel = sel;
    fill_color  = fill;
    enable      = 1'b1;
    tready      = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge aclk); #1;
      if (pop_cnt >= limit) enable = 1'b0;
      if (pop_cnt >= chg_at) fill_color = fill2;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check_val("run_complete", {31'd0, done}, 1);
    check_val("left_in_queue", exp_q.size(), 0);
    check_val("idle_tvalid", tvalid, 0);
    check_val("idle_busy", busy, 0);
    tready = 1'b1;
  endtask

  initial begin
    aresetn     = 1'b0;
    enable      = 1'b0;
    tready      = 1'b1;
    pattern_sel = 2'd0;
    fill_color  = 24'h0;
    f_model     = 8'd0;
    pop_cnt     = 0;

    // Solid fill, two frames with full throughput
    do_reset();
    run(2'd0, 24'h112233, 2, 1'b0, 1, 1000000, 24'h0);

    // Gradient under random backpressure; B follows frame count
    do_reset();
    run(2'd2, 24'h0, 2, 1'b1, 1, 1000000, 24'h0);

    // Colour bars
    do_reset();
    run(2'd1, 24'h0, 1, 1'b0, 1, 1000000, 24'h0);

    // Checker with 2-pixel squares
    do_reset();
    run(2'd3, 24'h0000FF, 1, 1'b0, 1, 1000000, 24'h0);

    // Enable drop and fill change mid-frame
    do_reset();
    run(2'd0, 24'h112233, 1, 1'b0, 10, 12, 24'hAABBCC);

    // Reset during a stall at beat 17, then a clean restart
    do_reset();
    push_frames(2'd2, 24'h0, 1);
    @(posedge aclk); #1;
    pattern_sel = 2'd2;
    enable      = 1'b1;
    for (int c = 0; c < 200 && pop_cnt < 17; c++) begin
      @(posedge aclk); #1;
    end
    check_val("reached_beat17", pop_cnt, 17);
    tready = 1'b0;
    @(posedge aclk); #3;
    aresetn = 1'b0;
    #1;
    check_val("async_tvalid", tvalid, 0);
    check_val("async_tuser", tuser, 0);
    check_val("async_tdata", tdata, 0);
    check_val("async_busy", busy, 0);
    exp_q.delete();
    f_model = 8'd0;
    enable  = 1'b0;
    tready  = 1'b1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    run(2'd2, 24'h0, 1, 1'b0, 1, 1000000, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
